// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: byte-stream sequencer driving a shared combinational ALU (optional accumulator chaining via ALU_ACC_CHAIN_EN)
module alu_seq_ctrl #(
  parameter int EXEC_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_result,
  output logic [7:0] res_data,
  output logic       res_zero,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       err,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, RESP} state_t;
  state_t state, nxt;
  logic [1:0] cnt;
  logic accept, legal, last, chain;
`ifdef ALU_ACC_CHAIN_EN
  logic [7:0] acc;
  assign chain = in_data[3];
`else
  assign chain = 1'b0;
`endif
  assign accept    = in_valid && in_ready;
  assign legal     = in_data[7:4] == 4'd0;
  assign last      = cnt == 2'(EXEC_LAT - 1);
  assign in_ready  = state == IDLE || state == LOAD_A || state == LOAD_B;
  assign busy      = state != IDLE;
  assign res_valid = state == RESP;
  assign res_zero  = res_data == 8'd0;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept && legal) nxt = chain ? (in_data[2:0] == 3'b111 ? EXEC : LOAD_B) : LOAD_A;
      LOAD_A:  if (accept) nxt = alu_op == 3'b111 ? EXEC : LOAD_B;
      LOAD_B:  if (accept) nxt = EXEC;
      EXEC:    if (last) nxt = RESP;
      RESP:    if (res_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      res_data <= '0;
      err      <= 1'b0;
      cnt      <= '0;
`ifdef ALU_ACC_CHAIN_EN
      acc      <= '0;
`endif
    end else begin
      err <= state == IDLE && accept && !legal;
      cnt <= (state == EXEC && !last) ? cnt + 2'd1 : 2'd0;
      if (state == IDLE && accept && legal) begin
        alu_op <= in_data[2:0];
`ifdef ALU_ACC_CHAIN_EN
        if (in_data[3]) alu_a <= acc;
`endif
      end
      if (state == LOAD_A && accept) alu_a <= in_data;
      if (state == LOAD_B && accept) alu_b <= in_data;
      if (state == EXEC && last) begin
        res_data <= alu_result;
`ifdef ALU_ACC_CHAIN_EN
        acc      <= alu_result;
`endif
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: scoreboard bench for alu_seq_ctrl with a transaction-level reference model
module tb_alu_seq_ctrl;
  localparam int EXEC_LAT = 1;
  logic       clk = 0, rst = 1;
  logic [7:0] in_data = 0;
  logic       in_valid = 0, res_ready = 0;
  logic       in_ready, res_zero, res_valid, err, busy;
  logic [7:0] alu_a, alu_b, alu_result, res_data;
  logic [2:0] alu_op;
  int checks = 0, failures = 0, cyc = 0, rr_mode = 0;
  typedef struct {logic [7:0] d; int c;} exp_t;
  exp_t q[$];
  logic [7:0] acc_m = 0, last_res = 0;

  alu_seq_ctrl #(.EXEC_LAT(EXEC_LAT)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .res_data(res_data), .res_zero(res_zero), .res_valid(res_valid), .res_ready(res_ready),
    .err(err), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~(a & b);
      3'd6: return ~(a | b);
      default: return ~a;
    endcase
  endfunction
  assign alu_result = alu_fn(alu_op, alu_a, alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor: latency on rising res_valid, hold while stalled, data on each transfer
  logic prev_v = 0, prev_r = 0;
  logic [7:0] prev_d = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) prev_v = 0;
    else begin
      if (res_valid && !prev_v) begin
        if (q.size() == 0) check("unexpected_res_valid", 1, 0);
        else check("latency", cyc - q[0].c, EXEC_LAT);
      end
      if (res_valid && prev_v && !prev_r) check("hold_res_data", res_data, prev_d);
      if (res_valid && res_ready && q.size() > 0) begin
        e = q.pop_front();
        check("res_data", res_data, e.d);
        check("res_zero", res_zero, e.d == 0);
        last_res = res_data;
      end
      prev_v = res_valid;
      prev_d = res_data;
      prev_r = res_ready;
    end
  end

  initial forever begin
    @(posedge clk);
    #1 res_ready = rr_mode == 1 ? 1'b0 : rr_mode == 2 ? 1'b1 : ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    in_data = b;
    in_valid = 1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic txn(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] am;
    am = a;
    send(cmd);
`ifdef ALU_ACC_CHAIN_EN
    if (cmd[3]) am = acc_m;
    else send(a);
`else
    send(a);
`endif
    if (cmd[2:0] != 3'b111) send(b);
    acc_m = alu_fn(cmd[2:0], am, b);
    q.push_back('{acc_m, cyc});
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || res_valid || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    rst = 1;
    repeat (3) @(negedge clk);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_zero", res_zero, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 0;
    rr_mode = 2;
    txn(8'h00, 8'h3C, 8'h0A); wait_drain(); check("add_3c_0a", last_res, 8'h46);
    txn(8'h01, 8'h05, 8'h07); wait_drain(); check("sub_05_07", last_res, 8'hFE);
    txn(8'h07, 8'h0F, 8'h00);
    check("not_in_ready_low", in_ready, 0);
    wait_drain(); check("not_0f", last_res, 8'hF0);
`ifdef ALU_ACC_CHAIN_EN
    txn(8'h00, 8'h10, 8'h20); wait_drain(); check("chain_base", last_res, 8'h30);
    txn(8'h08, 8'h00, 8'h05); wait_drain(); check("chain_add", last_res, 8'h35);
`else
    txn(8'h08, 8'h05, 8'h05); wait_drain(); check("chain_ignored", last_res, 8'h0A);
`endif
    @(negedge clk);
    in_data = 8'h40;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    check("illegal_err_pulse", err, 1);
    check("illegal_busy", busy, 0);
    @(negedge clk);
    check("illegal_err_end", err, 0);
    txn(8'h04, 8'hAA, 8'hAA); wait_drain(); check("xor_zero", last_res, 8'h00);
    rr_mode = 1;
    txn(8'h03, 8'h12, 8'h40);
    for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("stall_res_valid", res_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_res_data", res_data, 8'h52);
    end
    rr_mode = 2;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("release_res_valid", res_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("release_data", last_res, 8'h52);
    send(8'h00);
    send(8'h11);
    #2 rst = 1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_alu_a", alu_a, 0);
    check("async_rst_res_data", res_data, 0);
    acc_m = 0;
    @(negedge clk);
    rst = 0;
    txn(8'h02, 8'hF0, 8'h3C); wait_drain(); check("after_rst_and", last_res, 8'h30);
    rr_mode = 0;
    repeat (60) begin
      logic [7:0] cmd;
      cmd = {4'b0000, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))};
      txn(cmd, 8'($urandom), 8'($urandom));
    end
    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
